uart_tx_unit: RTL and testbench



---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_fifo.sv | 84 ++++++++
 rtl/uart_tx_unit.sv | 172 +++++++++++++++++
 tb/tb_uart_tx_unit.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART link constants, default parameters and FSM state type
//
// Purpose: common definitions for the transmit unit, the receive unit and the
//          UART interface block of the two-player link.
// Ports:   none (package).

package uart_pkg;

  // Handshake byte exchanged by both boards before a game starts.
  localparam logic [7:0] START_SIGNAL = 8'hFF;

  // Default frame / rate settings: 8N1 at 9600 baud from a 100 MHz clock.
  localparam int UART_DBIT    = 8;
  localparam int UART_SB_TICK = 16;
  localparam int UART_DVSR    = 651;
  localparam int UART_FIFO_W  = 2;

  // Oversampling ticks per start/data bit.
  localparam int UART_OS_TICKS = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_START = 2'b01,
    ST_DATA  = 2'b10,
    ST_STOP  = 2'b11
  } uart_state_t;

endpackage

// File: rtl/uart_fifo.sv
// rtl/uart_fifo.sv - small register FIFO with registered full/empty flags
//
// Purpose: byte queue between the game-side write strobe and the serializer;
//          also used by the receive unit.
// Ports:
//   clk      - system clock
//   rst      - asynchronous active-high reset (empties the FIFO)
//   i_wr     - push request; ignored while o_full
//   i_rd     - pop request; ignored while o_empty
//   i_data   - word to push
//   o_data   - word at the head of the queue (valid while !o_empty)
//   o_full   - 2**AW words held
//   o_empty  - no words held

module uart_fifo #(
  parameter int DW = 8,
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_wr,
  input  logic          i_rd,
  input  logic [DW-1:0] i_data,
  output logic [DW-1:0] o_data,
  output logic          o_full,
  output logic          o_empty
);

  logic [DW-1:0] r_mem [2**AW];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic          r_full;
  logic          r_empty;

  logic          w_push;
  logic          w_pop;
  logic [AW-1:0] w_wptr_nx;
  logic [AW-1:0] w_rptr_nx;

  // A push is gated by the registered full flag, so a push that coincides
  // with a pop on a full FIFO is still dropped.
  assign w_push    = i_wr & ~r_full;
  assign w_pop     = i_rd & ~r_empty;
  assign w_wptr_nx = r_wptr + AW'(1);
  assign w_rptr_nx = r_rptr + AW'(1);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= i_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          r_wptr  <= w_wptr_nx;
          r_empty <= 1'b0;
          r_full  <= (w_wptr_nx == r_rptr);
        end
        2'b01: begin
          r_rptr  <= w_rptr_nx;
          r_full  <= 1'b0;
          r_empty <= (w_rptr_nx == r_wptr);
        end
        2'b11: begin
          r_wptr <= w_wptr_nx;
          r_rptr <= w_rptr_nx;
        end
        default: ;
      endcase
    end
  end

  assign o_data  = r_mem[r_rptr];
  assign o_full  = r_full;
  assign o_empty = r_empty;

endmodule

// File: rtl/uart_tx_unit.sv
// rtl/uart_tx_unit.sv - buffered 8N1 UART transmitter for the two-player link
//
// Purpose: queues bytes written by the game-side UART interface and shifts
//          each one out LSB first as start / DBIT data / stop on the tx pin.
// Ports:
//   clk      - system clock
//   rst      - asynchronous active-high reset; aborts any frame in flight
//   wr_uart  - push strobe for w_data (dropped while tx_full)
//   w_data   - byte to send
//   tx_full  - transmit queue full
//   tx       - serial line, idle high, registered
//   tx_busy  - a frame is on the line

module uart_tx_unit
  import uart_pkg::*;
#(
  parameter int DBIT    = UART_DBIT,
  parameter int SB_TICK = UART_SB_TICK,
  parameter int DVSR    = UART_DVSR,
  parameter int FIFO_W  = UART_FIFO_W
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_uart,
  input  logic [7:0] w_data,
  output logic       tx_full,
  output logic       tx,
  output logic       tx_busy
);

  localparam int BW = (DVSR > 1) ? $clog2(DVSR) : 1;
  localparam int SW = (SB_TICK > UART_OS_TICKS) ? $clog2(SB_TICK) : $clog2(UART_OS_TICKS);
  localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

  localparam logic [BW-1:0] BAUD_LAST = BW'(DVSR - 1);
  localparam logic [SW-1:0] OS_LAST   = SW'(UART_OS_TICKS - 1);
  localparam logic [SW-1:0] SB_LAST   = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST    = NW'(DBIT - 1);

  uart_state_t    r_state;
  logic [BW-1:0]  r_baud;
  logic [SW-1:0]  r_s;
  logic [NW-1:0]  r_n;
  logic [DBIT-1:0] r_b;
  logic           r_tx;
  logic           r_busy;

  uart_state_t    w_state_nx;
  logic [SW-1:0]  w_s_nx;
  logic [NW-1:0]  w_n_nx;
  logic [DBIT-1:0] w_b_nx;
  logic           w_tx_nx;
  logic           w_pop;
  logic           w_tick;
  logic [7:0]     w_fifo_data;
  logic           w_fifo_empty;

  uart_fifo #(
    .DW (8),
    .AW (FIFO_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_wr    (wr_uart),
    .i_rd    (w_pop),
    .i_data  (w_data),
    .o_data  (w_fifo_data),
    .o_full  (tx_full),
    .o_empty (w_fifo_empty)
  );

  // Baud divider restarts on the pop edge so the start bit, and every bit
  // after it, spans exactly 16 full tick periods.
  assign w_tick = (r_baud == BAUD_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_baud <= '0;
    end else if (w_pop || w_tick) begin
      r_baud <= '0;
    end else begin
      r_baud <= r_baud + BW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_s     <= '0;
      r_n     <= '0;
      r_b     <= '0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_s     <= w_s_nx;
      r_n     <= w_n_nx;
      r_b     <= w_b_nx;
      r_tx    <= w_tx_nx;
      r_busy  <= (w_state_nx != ST_IDLE);
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_s_nx     = r_s;
    w_n_nx     = r_n;
    w_b_nx     = r_b;
    w_pop      = 1'b0;
    w_tx_nx    = 1'b1;

    case (r_state)
      ST_IDLE: begin
        if (!w_fifo_empty) begin
          w_pop      = 1'b1;
          w_b_nx     = w_fifo_data[DBIT-1:0];
          w_s_nx     = '0;
          w_n_nx     = '0;
          w_state_nx = ST_START;
        end
      end
      ST_START: begin
        if (w_tick) begin
          if (r_s == OS_LAST) begin
            w_s_nx     = '0;
            w_n_nx     = '0;
            w_state_nx = ST_DATA;
          end else begin
            w_s_nx = r_s + SW'(1);
          end
        end
      end
      ST_DATA: begin
        if (w_tick) begin
          if (r_s == OS_LAST) begin
            w_s_nx = '0;
            w_b_nx = r_b >> 1;
            if (r_n == N_LAST) begin
              w_state_nx = ST_STOP;
            end else begin
              w_n_nx = r_n + NW'(1);
            end
          end else begin
            w_s_nx = r_s + SW'(1);
          end
        end
      end
      ST_STOP: begin
        if (w_tick) begin
          if (r_s == SB_LAST) begin
            w_state_nx = ST_IDLE;
          end else begin
            w_s_nx = r_s + SW'(1);
          end
        end
      end
      default: w_state_nx = ST_IDLE;
    endcase

    // Line level is derived from the state being entered, so the registered
    // pin changes on the same edge as the state.
    case (w_state_nx)
      ST_START: w_tx_nx = 1'b0;
      ST_DATA:  w_tx_nx = w_b_nx[0];
      default:  w_tx_nx = 1'b1;
    endcase
  end

  assign tx      = r_tx;
  assign tx_busy = r_busy;

endmodule

// File: tb/tb_uart_tx_unit.sv
// tb/tb_uart_tx_unit.sv - scoreboard bench for uart_tx_unit with a queue-level reference model

module tb_uart_tx_unit;

  localparam int DVSR    = 4;
  localparam int BIT_CYC = 16 * DVSR;
  localparam int FRAME   = 10 * BIT_CYC;
  localparam int DEPTH   = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_uart = 1'b0;
  logic [7:0] w_data = 8'h00;
  logic       tx_full;
  logic       tx;
  logic       tx_busy;

  int cyc = 0;
  int total = 0;
  int bad = 0;

  // Reference model: pending bytes, earliest edge the next pop may occur,
  // and the scoreboard of (pop edge, byte) for frames expected on the line.
  logic [7:0] mq[$];
  int         exp_edge[$];
  logic [7:0] exp_byte[$];
  int         next_free = 0;

  int   full_err = 0;
  int   busy_cnt = 0;
  logic s_full;
  bit   in_frame = 0;
  bit   gap_pending = 0;
  int   nframes = 0;

  uart_tx_unit #(
    .DBIT    (8),
    .SB_TICK (16),
    .DVSR    (DVSR),
    .FIFO_W  (2)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .wr_uart (wr_uart),
    .w_data  (w_data),
    .tx_full (tx_full),
    .tx      (tx),
    .tx_busy (tx_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // One clock edge of the transmitter at queue level: a byte leaves when one
  // is waiting and the previous frame plus one idle cycle has elapsed; a push
  // lands only if fewer than DEPTH bytes were waiting before the edge.
  task automatic model_edge(input int e, input logic wr, input logic [7:0] d, input logic r);
    int cnt;
    if (r) begin
      mq.delete();
      exp_edge.delete();
      exp_byte.delete();
      next_free = 0;
      return;
    end
    cnt = mq.size();
    if (cnt > 0 && e >= next_free) begin
      exp_edge.push_back(e);
      exp_byte.push_back(mq.pop_front());
      next_free = e + FRAME + 1;
    end
    if (wr && cnt < DEPTH) mq.push_back(d);
  endtask

  task automatic step(input logic wr, input logic [7:0] d, input logic r);
    @(negedge clk);
    s_full = tx_full;
    if (!rst && (tx_full !== (mq.size() == DEPTH))) full_err++;
    if (tx_busy === 1'b1) busy_cnt++;
    rst     = r;
    wr_uart = wr;
    w_data  = d;
    model_edge(cyc + 1, wr, d, r);
  endtask

  // Monitor: frames are recognised on the line, paired with the oldest
  // scoreboard entry, and checked sample by sample.
  initial begin : monitor
    int         k;
    int         idx;
    int         bit_err;
    int         want_edge;
    int         fstart;
    logic       exp_bit;
    logic [7:0] fbyte;
    logic [7:0] rx;
    bit_err = 0;
    fstart  = 0;
    fbyte   = 8'h00;
    rx      = 8'h00;
    forever begin
      @(negedge clk);
      if (rst) begin
        in_frame    = 0;
        gap_pending = 0;
        bit_err     = 0;
      end else if (gap_pending) begin
        gap_pending = 0;
        chk("gap_idle_tx_busy", {30'd0, tx, tx_busy}, 32'd2);
      end else if (in_frame) begin
        k   = cyc - fstart;
        idx = k / BIT_CYC;
        if (idx == 0) exp_bit = 1'b0;
        else if (idx == 9) exp_bit = 1'b1;
        else exp_bit = fbyte[idx-1];
        if (tx !== exp_bit || tx_busy !== 1'b1) bit_err++;
        if ((k % BIT_CYC) == BIT_CYC / 2 && idx >= 1 && idx <= 8) rx[idx-1] = tx;
        if ((k % BIT_CYC) == BIT_CYC - 1) begin
          chk($sformatf("frame%0d_bit%0d_errs", nframes, idx), bit_err, 0);
          bit_err = 0;
        end
        if (k == FRAME - 1) begin
          chk($sformatf("frame%0d_byte", nframes), {24'd0, rx}, {24'd0, fbyte});
          in_frame    = 0;
          gap_pending = 1;
          nframes++;
        end
      end else if (tx === 1'b0) begin
        chk("frame_expected", exp_edge.size() > 0, 1);
        if (exp_edge.size() > 0) begin
          want_edge = exp_edge.pop_front();
          fbyte     = exp_byte.pop_front();
          chk("frame_start_edge", cyc, want_edge);
        end else begin
          fbyte = 8'h00;
        end
        fstart   = cyc;
        in_frame = 1;
        rx       = 8'h00;
        bit_err  = (tx_busy !== 1'b1) ? 1 : 0;
      end
    end
  end

  initial begin : driver
    int errs;
    int guard;
    int n0;

    // Reset state
    repeat (3) step(1'b0, 8'h00, 1'b1);
    #1;
    chk("reset_tx", tx, 1);
    chk("reset_busy", tx_busy, 0);
    chk("reset_full", tx_full, 0);

    // Quiet line for 1000 cycles
    errs = 0;
    repeat (1000) begin
      step(1'b0, 8'h00, 1'b0);
      if (tx !== 1'b1 || tx_busy !== 1'b0 || tx_full !== 1'b0) errs++;
    end
    chk("idle_1000_errs", errs, 0);

    // Single 0xFF frame, then 0xA5
    busy_cnt = 0;
    step(1'b1, 8'hFF, 1'b0);
    repeat (700) step(1'b0, 8'h00, 1'b0);
    chk("busy_len_ff", busy_cnt, FRAME);

    busy_cnt = 0;
    step(1'b1, 8'hA5, 1'b0);
    repeat (700) step(1'b0, 8'h00, 1'b0);
    chk("busy_len_a5", busy_cnt, FRAME);

    // Six back-to-back pushes: sixth must meet a full queue
    for (int i = 1; i <= 5; i++) step(1'b1, 8'(i), 1'b0);
    chk("full_before_5th_push", s_full, 0);
    step(1'b1, 8'h06, 1'b0);
    chk("full_on_6th_push", s_full, 1);
    repeat (5 * (FRAME + 1) + 100) step(1'b0, 8'h00, 1'b0);

    // Reset in the middle of DATA with two bytes queued
    step(1'b1, 8'h00, 1'b0);
    step(1'b1, 8'h11, 1'b0);
    step(1'b1, 8'h22, 1'b0);
    repeat (150) step(1'b0, 8'h00, 1'b0);
    n0 = nframes;
    step(1'b0, 8'h00, 1'b1);
    #1;
    chk("async_rst_tx", tx, 1);
    chk("async_rst_busy", tx_busy, 0);
    chk("async_rst_full", tx_full, 0);
    repeat (2) step(1'b0, 8'h00, 1'b1);
    repeat (1000) step(1'b0, 8'h00, 1'b0);
    chk("no_frames_after_rst", nframes, n0);
    chk("post_rst_busy", tx_busy, 0);
    chk("post_rst_full", tx_full, 0);

    // Push on the pop edge of a full queue is dropped
    step(1'b1, 8'h3C, 1'b0);
    step(1'b1, 8'hC1, 1'b0);
    step(1'b1, 8'hC2, 1'b0);
    step(1'b1, 8'hC3, 1'b0);
    step(1'b1, 8'hC4, 1'b0);
    guard = 0;
    while (cyc + 2 < next_free && guard < 2000) begin
      step(1'b0, 8'h00, 1'b0);
      guard++;
    end
    chk("pop_edge_reached", guard < 2000, 1);
    step(1'b1, 8'h77, 1'b0);
    chk("full_at_pop_edge", s_full, 1);
    step(1'b0, 8'h00, 1'b0);
    chk("not_full_after_pop", s_full, 0);

    // Randomised traffic with occasional bursts
    repeat (6000) begin
      if ($urandom_range(0, 999) == 0) begin
        repeat (6) step(1'b1, 8'($urandom), 1'b0);
      end else if ($urandom_range(0, 149) == 0) begin
        step(1'b1, 8'($urandom), 1'b0);
      end else begin
        step(1'b0, 8'h00, 1'b0);
      end
    end

    // Drain
    guard = 0;
    while ((exp_edge.size() > 0 || mq.size() > 0 || in_frame || gap_pending) && guard < 20000) begin
      step(1'b0, 8'h00, 1'b0);
      guard++;
    end
    chk("drain_done", guard < 20000, 1);
    chk("full_track_errs", full_err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
